align_tx_32b: RTL

TX gearbox for the 10GBASE-R PCS. It accepts 64b/66b blocks from the scrambler as two 32-bit halves plus a 2-bit sync header. It emits a continuous 32-bit word stream every clock to the transceiver, with bit 0 sent first. It is the transmit counterpart of align_rx_32b: a 33-cycle sequence accepts 32 words (16 blocks) and stalls the source for one cycle.

---
 rtl/pcs_pkg.sv | 34 +++
 rtl/align_tx_32b_if.sv | 23 ++
 rtl/align_tx_merge.sv | 46 ++++
 rtl/align_tx_32b.sv | 78 +++++++
 4 files changed

// File: rtl/pcs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pcs_pkg
//  Description : Constants and types shared by the 10GBASE-R PCS gearboxes
//                (align_tx_32b and align_rx_32b).
//                  SYNC_DATA / SYNC_CTRL : legal 64b/66b sync headers
//                  GB_SEQ_LAST           : stall slot of the 33-cycle sequence
//                  GB_WORDS              : words accepted per sequence
//                  gb_res_count()        : residual bit count held at a seq
//  Revision    : 1.0  initial release
// ============================================================================
package pcs_pkg;

    typedef logic [1:0] sync_hdr_t;

    localparam sync_hdr_t   SYNC_DATA   = 2'b01;
    localparam sync_hdr_t   SYNC_CTRL   = 2'b10;
    localparam logic [5:0]  GB_SEQ_LAST = 6'd32;
    localparam int          GB_WORDS    = 32;

    // Number of residual bits held in the register while the counter sits
    // at 'seq', i.e. the count left behind by the word accepted at seq-1.
    // Every block adds two header bits, so the count grows by 2 per block
    // and is exactly 32 when the stall slot drains it.
    function automatic logic [5:0] gb_res_count(input logic [5:0] seq);
        logic [5:0] prev;
        prev = seq - 6'd1;
        if (seq == 6'd0)
            return 6'd0;
        return (prev & 6'h3E) + 6'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/align_tx_32b_if.sv
`default_nettype none
// ============================================================================
//  Module      : align_tx_32b_if
//  Description : Source-side bus of the TX gearbox.
//                  din     : block half (even = payload[31:0], odd = [63:32])
//                  ctrl    : sync header, meaningful on even words only
//                  din_rdy : din/ctrl consumed at the next rising edge
//                  even    : consumed word is the first half of a block
//                master = scrambler side, slave = gearbox side.
//  Revision    : 1.0  initial release
// ============================================================================
interface align_tx_32b_if;

    logic [31:0]        din;
    pcs_pkg::sync_hdr_t ctrl;
    logic               din_rdy;
    logic               even;

    modport master (output din, ctrl, input  din_rdy, even);
    modport slave  (input  din, ctrl, output din_rdy, even);

endinterface
`default_nettype wire

// File: rtl/align_tx_merge.sv
`default_nettype none
// ============================================================================
//  Module      : align_tx_merge
//  Description : Combinational merge of the residual bits with the incoming
//                word (and the sync header on even words). Bit 0 of the
//                result is the next bit on the wire.
//                  i_res / i_res_cnt : residual bits and their count (0..32)
//                  i_din / i_ctrl    : incoming word and header
//                  i_accept          : a word is consumed this cycle
//                  i_even            : consumed word carries the header
//                  o_stream          : 66-bit merged stream
//  Revision    : 1.0  initial release
// ============================================================================
module align_tx_merge
    import pcs_pkg::*;
(
    input  wire logic [31:0] i_res,
    input  wire logic [5:0]  i_res_cnt,
    input  wire logic [31:0] i_din,
    input  wire sync_hdr_t   i_ctrl,
    input  wire logic        i_accept,
    input  wire logic        i_even,
    output logic      [65:0] o_stream
);

    logic [65:0] w_mask;
    logic [65:0] w_res;

    // Only the valid residual bits survive; stale upper bits are masked off.
    assign w_mask = (66'd1 << i_res_cnt) - 66'd1;
    assign w_res  = {34'd0, i_res} & w_mask;

    always_comb begin
        o_stream = w_res;
        if (i_accept) begin
            if (i_even)
                o_stream = w_res
                         | ({64'd0, i_ctrl} << i_res_cnt)
                         | ({34'd0, i_din}  << (i_res_cnt + 6'd2));
            else
                o_stream = w_res | ({34'd0, i_din} << i_res_cnt);
        end
    end

endmodule
`default_nettype wire

// File: rtl/align_tx_32b.sv
`default_nettype none
// ============================================================================
//  Module      : align_tx_32b
//  Description : 10GBASE-R TX gearbox, 66-bit blocks -> 32-bit words.
//                Accepts 32 words (16 blocks) per 33-cycle sequence and
//                stalls the source in the last slot to drain the residual.
//                  clk     : PMA TX word clock
//                  rst     : synchronous active-high reset
//                  bus     : source bus (din, ctrl, din_rdy, even)
//                  dout    : registered word to PMA, LSB first
//                  hdr_err : one-cycle pulse, illegal header accepted
//  Revision    : 1.0  initial release
// ============================================================================
module align_tx_32b
    import pcs_pkg::*;
#(
    parameter bit          CHECK_HDR = 1'b1,
    parameter logic [31:0] RST_WORD  = 32'h0000_0000
)(
    input  wire logic        clk,
    input  wire logic        rst,
    align_tx_32b_if.slave    bus,
    output logic      [31:0] dout,
    output logic             hdr_err
);

    logic [5:0]  r_seq;
    logic [31:0] r_res;
    logic [31:0] r_dout;
    logic        r_hdr_err;

    logic [5:0]  w_res_cnt;
    logic        w_rdy;
    logic        w_even;
    logic        w_hdr_bad;
    logic [65:0] w_stream;
    logic [1:0]  w_unused_hi;

    assign w_res_cnt = gb_res_count(r_seq);
    assign w_rdy     = !rst && (r_seq != GB_SEQ_LAST);
    assign w_even    = w_rdy && !r_seq[0];
    assign w_hdr_bad = (bus.ctrl == 2'b00) || (bus.ctrl == 2'b11);

    // The residual never exceeds 32 bits, so the top two stream bits are
    // always zero.
    assign w_unused_hi = w_stream[65:64];

    align_tx_merge u_merge (
        .i_res     (r_res),
        .i_res_cnt (w_res_cnt),
        .i_din     (bus.din),
        .i_ctrl    (bus.ctrl),
        .i_accept  (w_rdy),
        .i_even    (w_even),
        .o_stream  (w_stream)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq     <= 6'd0;
            r_res     <= 32'd0;
            r_dout    <= RST_WORD;
            r_hdr_err <= 1'b0;
        end else begin
            r_seq     <= (r_seq == GB_SEQ_LAST) ? 6'd0 : r_seq + 6'd1;
            r_dout    <= w_stream[31:0];
            r_res     <= w_stream[63:32];
            r_hdr_err <= CHECK_HDR && w_even && w_hdr_bad;
        end
    end

    assign bus.din_rdy = w_rdy;
    assign bus.even    = w_even;
    assign dout        = r_dout;
    assign hdr_err     = r_hdr_err;

endmodule
`default_nettype wire
